// File: rtl/stopwatch_pkg.sv
// Shared types and seven-segment glyphs for the BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    // Active-high segments ordered {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_glyph(input bcd_t d);
        case (d)
            4'd0:    seg_glyph = SEG_0;
            4'd1:    seg_glyph = SEG_1;
            4'd2:    seg_glyph = SEG_2;
            4'd3:    seg_glyph = SEG_3;
            4'd4:    seg_glyph = SEG_4;
            4'd5:    seg_glyph = SEG_5;
            4'd6:    seg_glyph = SEG_6;
            4'd7:    seg_glyph = SEG_7;
            4'd8:    seg_glyph = SEG_8;
            4'd9:    seg_glyph = SEG_9;
            default: seg_glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: synchronous clear, increment on inc, combinational carry at 9.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic carry_out,
    output bcd_t q
);

    assign carry_out = inc && (q == 4'd9);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q >= 4'd9) ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// Cascaded BCD stopwatch with start/pause/clear FSM and multiplexed 7-seg scan.
// Optional display freeze (lap) when STOPWATCH_LAP_EN is defined.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  btn_start,
    input  logic                  btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic                  btn_lap,
`endif
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  running,
    output logic                  overflow
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    sw_state_t        state, state_next;
    logic             start_q, clear_q;
    logic             start_edge, clear_edge, count_en;
    logic [DIGITS:0]  carry;
    bcd_t             digit_q    [DIGITS];
    bcd_t             disp_digit [DIGITS];
    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] idx;

    assign start_edge = btn_start & ~start_q;
    assign clear_edge = btn_clear & ~clear_q;
    assign count_en   = (state == RUN) && tick && !clear_edge;
    assign running    = (state == RUN);
    assign carry[0]   = count_en;

    always_comb begin
        state_next = state;
        if (clear_edge) begin
            state_next = IDLE;
        end else if (start_edge) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            start_q  <= 1'b0;
            clear_q  <= 1'b0;
            state    <= IDLE;
            overflow <= 1'b0;
        end else begin
            start_q <= btn_start;
            clear_q <= btn_clear;
            state   <= state_next;
            if (clear_edge) begin
                overflow <= 1'b0;
            end else if (carry[DIGITS]) begin
                overflow <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit u_digit (
            .clk_in    (clk_in),
            .reset     (reset),
            .clr       (clear_edge),
            .inc       (carry[gi]),
            .carry_out (carry[gi+1]),
            .q         (digit_q[gi])
        );
        assign bcd_out[4*gi +: 4] = digit_q[gi];
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_q, lap_on;
    logic lap_edge;
    bcd_t lap_digit [DIGITS];

    assign lap_edge = btn_lap & ~lap_q;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            lap_q  <= 1'b0;
            lap_on <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) lap_digit[i] <= '0;
        end else begin
            lap_q <= btn_lap;
            if (clear_edge) begin
                lap_on <= 1'b0;
            end else if (lap_edge && state != IDLE) begin
                lap_on <= ~lap_on;
                if (!lap_on) begin
                    for (int unsigned i = 0; i < DIGITS; i++) lap_digit[i] <= digit_q[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_disp
        assign disp_digit[gi] = lap_on ? lap_digit[gi] : digit_q[gi];
    end
`else
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_disp
        assign disp_digit[gi] = digit_q[gi];
    end
`endif

    // Scan runs in every state; an/seg are registered copies of the current index.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= DIGITS'(1);
            seg      <= SEG_0;
        end else begin
            an  <= DIGITS'(1) << idx;
            seg <= seg_glyph(disp_digit[idx]);
            if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomized and directed bench for bcd_stopwatch against a decimal-arithmetic model.
module tb_bcd_stopwatch;

    localparam int unsigned D    = 4;
    localparam int unsigned SDIV = 4;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        tick, btn_start, btn_clear;
`ifdef STOPWATCH_LAP_EN
    logic        btn_lap;
`endif
    logic [15:0] bcd_out;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        running, overflow;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk_in = ~clk_in;

    bcd_stopwatch #(.DIGITS(D), .SCAN_DIV(SDIV)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .tick      (tick),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
`ifdef STOPWATCH_LAP_EN
        .btn_lap   (btn_lap),
`endif
        .bcd_out   (bcd_out),
        .seg       (seg),
        .an        (an),
        .running   (running),
        .overflow  (overflow)
    );

    // Reference model: count as a plain integer, state as 0=idle 1=run 2=pause.
    int unsigned m_count, m_lap_val, m_state, m_scan, m_idx;
    bit          m_ovf, m_lap_on, p_start, p_clear, p_lap;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;

    function automatic logic [6:0] glyph(input int unsigned d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int unsigned digit_of(input int unsigned v, input int unsigned i);
        int unsigned p = 1;
        for (int unsigned k = 0; k < i; k++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r = '0;
        for (int unsigned i = 0; i < D; i++) r[4*i +: 4] = 4'(digit_of(v, i));
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_lap_val = 0; m_state = 0; m_scan = 0; m_idx = 0;
        m_ovf = 0; m_lap_on = 0; p_start = 0; p_clear = 0; p_lap = 0;
        m_an = 4'b0001; m_seg = 7'h3F;
    endtask

    task automatic model_step(input bit t, input bit s, input bit c, input bit l);
        int unsigned disp;
        bit ce, se, le;
        disp  = m_lap_on ? m_lap_val : m_count;
        m_an  = 4'(1 << m_idx);
        m_seg = glyph(digit_of(disp, m_idx));
        ce = c & ~p_clear; se = s & ~p_start; le = l & ~p_lap;
        p_clear = c; p_start = s; p_lap = l;
        if (ce) begin
            m_count = 0; m_ovf = 0; m_state = 0; m_lap_on = 0;
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (le && m_state != 0) begin
                if (m_lap_on) m_lap_on = 0;
                else begin m_lap_val = m_count; m_lap_on = 1; end
            end
`endif
            if (m_state == 1 && t) begin
                m_count++;
                if (m_count == 10000) begin m_count = 0; m_ovf = 1; end
            end
            if (se) m_state = (m_state == 1) ? 2 : 1;
        end
        if (m_scan == SDIV - 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % D;
        end else begin
            m_scan++;
        end
    endtask

    task automatic compare_all();
        check("bcd_out",  32'(bcd_out),  32'(to_bcd(m_count)));
        check("running",  32'(running),  32'(m_state == 1));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("an",       32'(an),       32'(m_an));
        check("seg",      32'(seg),      32'(m_seg));
    endtask

    // Drive inputs, let one edge pass, update model, compare on the falling edge.
    task automatic cycle(input bit t, input bit s, input bit c, input bit l);
        tick = t; btn_start = s; btn_clear = c;
`ifdef STOPWATCH_LAP_EN
        btn_lap = l;
`endif
        @(posedge clk_in);
        model_step(t, s, c, l);
        @(negedge clk_in);
        compare_all();
    endtask

    task automatic press_start(); cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); endtask
    task automatic press_clear(); cycle(0, 0, 1, 0); cycle(0, 0, 0, 0); endtask
    task automatic press_lap();   cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); endtask
    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1, 0, 0, 0);
    endtask

    task automatic wait_an(input string tag, input logic [3:0] target);
        int unsigned k = 0;
        while (an !== target && k < 16) begin
            cycle(0, 0, 0, 0);
            k++;
        end
        check(tag, 32'(an), 32'(target));
    endtask

    initial begin
        reset = 1'b0; tick = 0; btn_start = 0; btn_clear = 0;
`ifdef STOPWATCH_LAP_EN
        btn_lap = 0;
`endif
        model_reset();
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_run", 32'(running), 32'h0);
        check("rst_seg", 32'(seg), 32'h3F);
        check("rst_an",  32'(an), 32'h1);

        ticks(10);
        check("idle_bcd", 32'(bcd_out), 32'h0);
        check("idle_run", 32'(running), 32'h0);

        press_start();
        ticks(123);
        check("cnt123", 32'(bcd_out), 32'h0123);
        check("cnt123_run", 32'(running), 32'h1);
        press_start();
        ticks(5);
        check("pause_hold", 32'(bcd_out), 32'h0123);

        press_clear();
        press_start();
        ticks(9998);
        check("pre_ovf", 32'(bcd_out), 32'h9998);
        ticks(2);
        check("wrap_bcd", 32'(bcd_out), 32'h0000);
        check("wrap_ovf", 32'(overflow), 32'h1);
        press_clear();
        check("clr_ovf", 32'(overflow), 32'h0);
        check("clr_idle", 32'(running), 32'h0);

        press_start();
        ticks(17);
        cycle(1, 1, 1, 0);
        check("clr_prio_bcd", 32'(bcd_out), 32'h0);
        check("clr_prio_run", 32'(running), 32'h0);
        cycle(0, 0, 0, 0);
        for (int unsigned i = 0; i < 50; i++) cycle(1, 1, 0, 0);
        check("held_start", 32'(running), 32'h1);
        cycle(0, 0, 0, 0);

        press_clear();
        press_start();
        ticks(4321);
        press_start();
        for (int unsigned d = 0; d < D; d++) begin
            wait_an("scan_an", 4'(1 << d));
            check("scan_seg", 32'(seg), 32'(glyph(d + 1)));
        end

`ifdef STOPWATCH_LAP_EN
        press_clear();
        press_start();
        ticks(10);
        check("lap_pre", 32'(bcd_out), 32'h0010);
        press_lap();
        ticks(20);
        check("lap_live", 32'(bcd_out), 32'h0030);
        wait_an("lap_an", 4'b0010);
        check("lap_frozen", 32'(seg), 32'(glyph(1)));
        press_lap();
        cycle(0, 0, 0, 0);
        wait_an("lap_an2", 4'b0010);
        check("lap_release", 32'(seg), 32'(glyph(3)));
`endif

        for (int unsigned i = 0; i < 1500; i++) begin
            cycle(bit'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 63) == 0,
                  $urandom_range(0, 15) == 0);
        end

        press_clear();
        press_start();
        ticks(7);
        reset = 1'b0;
        #1;
        check("arst_bcd", 32'(bcd_out), 32'h0);
        check("arst_run", 32'(running), 32'h0);
        check("arst_ovf", 32'(overflow), 32'h0);
        check("arst_an",  32'(an), 32'h1);
        check("arst_seg", 32'(seg), 32'h3F);
        #1;
        reset = 1'b1;
        model_reset();
        ticks(3);
        check("post_rst_bcd", 32'(bcd_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
